// File: rtl/pipeline_stall_controller_if.sv
// Hazard/handshake bundle between the EX-stage hazard sequencer and the pipeline.
// The master side is the sequencer: it observes hazard inputs and drives the
// stall/flush/MUL-DIV controls. The slave side is the pipeline (or a bench).
interface pipeline_stall_controller_if;
  // Hazard inputs from the ID and EX stages
  logic       ResultSrcE0;
  logic [4:0] RD_E;
  logic [4:0] Rs1_D;
  logic [4:0] Rs2_D;
  logic       PCSrcE;
  logic       MulDivE;
  logic [1:0] MulDivOpE;

  // Pipeline-register controls and MUL/DIV handshake
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       FlushD;
  logic       FlushE;
  logic       MdStart;
  logic       MdBusy;
  logic       MdDone;

  modport master (
    input  ResultSrcE0, RD_E, Rs1_D, Rs2_D, PCSrcE, MulDivE, MulDivOpE,
    output StallF, StallD, StallE, FlushD, FlushE, MdStart, MdBusy, MdDone
  );

  modport slave (
    output ResultSrcE0, RD_E, Rs1_D, Rs2_D, PCSrcE, MulDivE, MulDivOpE,
    input  StallF, StallD, StallE, FlushD, FlushE, MdStart, MdBusy, MdDone
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Hazard sequencer for the 5-stage RISC-V pipeline.
// Load-use and taken-branch hazards produce combinational stall/flush controls.
// A MUL/DIV op in EX is sequenced by a small IDLE/BUSY/DONE FSM that holds F/D/E
// for LAT-1 cycles (starting with the MdStart cycle) and pulses MdDone in cycle LAT.
// While the MUL/DIV sequence stalls the pipe, load-use and branch controls are
// masked so FlushE never coincides with StallE.
module pipeline_stall_controller #(
  parameter int LAT_MUL = 4,
  parameter int LAT_DIV = 33,
  parameter int CNT_W   = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  pipeline_stall_controller_if.master   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_t;

  // Counter preload: the start cycle and the DONE cycle are not counted down.
  localparam logic [CNT_W-1:0] LOAD_MUL = CNT_W'(LAT_MUL - 2);
  localparam logic [CNT_W-1:0] LOAD_DIV = CNT_W'(LAT_DIV - 2);
  localparam logic             MUL_IS_2 = (LAT_MUL == 2) ? 1'b1 : 1'b0;
  localparam logic             DIV_IS_2 = (LAT_DIV == 2) ? 1'b1 : 1'b0;

  md_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_md_busy;
  logic             r_md_done;

  logic             w_start;
  logic             w_is_div;
  logic [CNT_W-1:0] w_load;
  logic             w_short;
  logic             w_md_stall;
  logic             w_lw;
  logic             w_hz_en;

  logic             w_stall_f;
  logic             w_stall_d;
  logic             w_stall_e;
  logic             w_flush_d;
  logic             w_flush_e;
  logic             w_md_start;
  logic             w_md_busy;
  logic             w_md_done;

  // Latency selection for an op being launched this cycle
  always_comb begin
    w_is_div = bus.MulDivOpE[1];
    if (w_is_div) begin
      w_load  = LOAD_DIV;
      w_short = DIV_IS_2;
    end else begin
      w_load  = LOAD_MUL;
      w_short = MUL_IS_2;
    end
  end

  // Start is only honoured from IDLE; a MulDivE seen in BUSY or DONE is ignored
  always_comb begin
    if ((r_state == ST_IDLE) && bus.MulDivE && !rst) begin
      w_start = 1'b1;
    end else begin
      w_start = 1'b0;
    end
  end

  // MUL/DIV sequencer: state, countdown and registered busy/done flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_md_busy <= 1'b0;
      r_md_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.MulDivE) begin
            r_cnt <= w_load;
            if (w_short) begin
              r_state   <= ST_DONE;
              r_md_busy <= 1'b0;
              r_md_done <= 1'b1;
            end else begin
              r_state   <= ST_BUSY;
              r_md_busy <= 1'b1;
              r_md_done <= 1'b0;
            end
          end else begin
            r_state   <= ST_IDLE;
            r_md_busy <= 1'b0;
            r_md_done <= 1'b0;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state   <= ST_DONE;
            r_md_busy <= 1'b0;
            r_md_done <= 1'b1;
          end else begin
            r_state   <= ST_BUSY;
            r_md_busy <= 1'b1;
            r_md_done <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_cnt     <= {CNT_W{1'b0}};
          r_md_busy <= 1'b0;
          r_md_done <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= {CNT_W{1'b0}};
          r_md_busy <= 1'b0;
          r_md_done <= 1'b0;
        end
      endcase
    end
  end

  // Hazard detection; the MUL/DIV stall window masks load-use and branch controls
  always_comb begin
    w_md_stall = w_start | r_md_busy;
    w_hz_en    = ~w_md_stall;
    if (bus.ResultSrcE0 && (bus.RD_E != 5'd0) &&
        ((bus.RD_E == bus.Rs1_D) || (bus.RD_E == bus.Rs2_D))) begin
      w_lw = 1'b1;
    end else begin
      w_lw = 1'b0;
    end
  end

  // Output combination; everything is forced low while reset is held
  always_comb begin
    if (rst) begin
      w_stall_f  = 1'b0;
      w_stall_d  = 1'b0;
      w_stall_e  = 1'b0;
      w_flush_d  = 1'b0;
      w_flush_e  = 1'b0;
      w_md_start = 1'b0;
      w_md_busy  = 1'b0;
      w_md_done  = 1'b0;
    end else begin
      w_stall_f  = w_md_stall | (w_lw & w_hz_en);
      w_stall_d  = w_md_stall | (w_lw & w_hz_en);
      w_stall_e  = w_md_stall;
      w_flush_d  = bus.PCSrcE & w_hz_en;
      w_flush_e  = (w_lw | bus.PCSrcE) & w_hz_en;
      w_md_start = w_start;
      w_md_busy  = r_md_busy;
      w_md_done  = r_md_done;
    end
  end

  assign bus.StallF  = w_stall_f;
  assign bus.StallD  = w_stall_d;
  assign bus.StallE  = w_stall_e;
  assign bus.FlushD  = w_flush_d;
  assign bus.FlushE  = w_flush_e;
  assign bus.MdStart = w_md_start;
  assign bus.MdBusy  = w_md_busy;
  assign bus.MdDone  = w_md_done;

endmodule
